// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the byte-serial program loader.
// Holds the loader FSM state encoding and word-packing constants.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;

  function automatic logic is_busy(input loader_state_t s);
    return (s == S_LOAD) || (s == S_WRITE);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Byte handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
// byte_last qualifies byte_valid; the source may drop byte_valid freely between bytes.
interface prog_loader_if #(
  parameter int XLEN        = 32,
  parameter int INSTR_MEM_W = 10
);

  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   byte_last;
  logic                   byte_ready;
  logic                   mem_wen;
  logic [INSTR_MEM_W-1:0] mem_waddr;
  logic [XLEN-1:0]        mem_wdata;

  modport master (
    output byte_valid, byte_data, byte_last,
    input  byte_ready, mem_wen, mem_waddr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data, byte_last,
    output byte_ready, mem_wen, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/prog_loader.sv
// Packs little-endian bytes into 32-bit words, writes them from address 0 upward,
// and holds the core in reset until the whole program has been written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int INSTR_MEM_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  prog_loader_if.slave           bus,
  output logic                   core_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [INSTR_MEM_W-2:0] n_words,
  output loader_state_t          o_dbg_state
);

  localparam int NW = INSTR_MEM_W - 1;
  localparam logic [NW-1:0]          MAX_WORDS = {1'b1, {(INSTR_MEM_W-2){1'b0}}};
  localparam logic [NW-1:0]          ONE_WORD  = {{(INSTR_MEM_W-2){1'b0}}, 1'b1};
  localparam logic [INSTR_MEM_W-1:0] TOP_ADDR  = {{(INSTR_MEM_W-2){1'b1}}, 2'b00};
  localparam logic [INSTR_MEM_W-1:0] ADDR_STEP = {{(INSTR_MEM_W-3){1'b0}}, 3'b100};

  loader_state_t          r_state;
  logic [BYTE_IDX_W-1:0]  r_k;
  logic [INSTR_MEM_W-1:0] r_addr;
  logic [XLEN-1:0]        r_word;
  logic [NW-1:0]          r_nwords;
  logic                   r_last;

  logic w_full;
  assign w_full = (r_nwords == MAX_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_addr   <= '0;
      r_word   <= '0;
      r_nwords <= '0;
      r_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state  <= S_LOAD;
            r_k      <= '0;
            r_addr   <= '0;
            r_nwords <= '0;
            r_last   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.byte_valid) begin
            // Memory already full: any further byte is an overflow, never stored.
            if (w_full) begin
              r_state <= S_ERR;
            end else begin
              r_word[{r_k, 3'b000} +: 8] <= bus.byte_data;
              r_k    <= r_k + 2'd1;
              r_last <= bus.byte_last;
              if (r_k == 2'd3)         r_state <= S_WRITE;
              else if (bus.byte_last) r_state <= S_ERR;
            end
          end
        end
        S_WRITE: begin
          r_k      <= '0;
          r_nwords <= r_nwords + ONE_WORD;
          if (r_addr != TOP_ADDR) r_addr <= r_addr + ADDR_STEP;
          r_state  <= r_last ? S_DONE : S_LOAD;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Every output is a decode of the state or a register; no input reaches an output combinationally.
  assign bus.byte_ready = (r_state == S_LOAD);
  assign bus.mem_wen    = (r_state == S_WRITE);
  assign bus.mem_waddr  = r_addr;
  assign bus.mem_wdata  = r_word;
  assign core_rst_n     = (r_state == S_DONE);
  assign busy           = is_busy(r_state);
  assign done           = (r_state == S_DONE);
  assign err            = (r_state == S_ERR);
  assign n_words        = r_nwords;
  assign o_dbg_state    = r_state;

  a_waddr_aligned : assert property (@(posedge clk) disable iff (rst) r_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a small (4-word) memory so overflow is reachable.
// Writes are scoreboarded against an expected {addr,data} queue.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-2:0] n_words;
  loader_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+XLEN-1:0] exp_q[$];

  prog_loader_if #(.XLEN(XLEN), .INSTR_MEM_W(AW)) bus ();

  prog_loader #(.XLEN(XLEN), .INSTR_MEM_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus.slave),
    .core_rst_n  (core_rst_n),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .n_words     (n_words),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write pulse is matched against the head of exp_q
  always @(negedge clk) begin
    if (bus.mem_wen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.mem_wen), 64'(0));
      end else begin
        logic [AW+XLEN-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.mem_waddr), 64'(e[AW+XLEN-1:XLEN]));
        check("wr_data", 64'(bus.mem_wdata), 64'(e[XLEN-1:0]));
      end
    end
  end

  // driver tasks (all called at a falling edge)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    check("ready_before_start", 64'(bus.byte_ready), 64'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_after_start", 64'(bus.byte_ready), 64'(1));
    check("busy_after_start", 64'(busy), 64'(1));
    check("core_rst_n_load", 64'(core_rst_n), 64'(0));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int max_gap);
    int n = 0;
    logic acc = 1'b0;
    int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int i = 0; i < gap; i++) begin
      bus.byte_valid = 1'b0;
      tick();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    bus.byte_last  = last;
    while (!acc && n < 40) begin
      acc = bus.byte_ready;
      tick();
      n++;
    end
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    if (!acc) check("byte_accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_state"}, 64'(dbg_state), 64'(S_IDLE));
    check({phase, "_ready"}, 64'(bus.byte_ready), 64'(0));
    check({phase, "_wen"}, 64'(bus.mem_wen), 64'(0));
    check({phase, "_waddr"}, 64'(bus.mem_waddr), 64'(0));
    check({phase, "_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check({phase, "_core_rst_n"}, 64'(core_rst_n), 64'(0));
    check({phase, "_busy"}, 64'(busy), 64'(0));
    check({phase, "_done"}, 64'(done), 64'(0));
    check({phase, "_err"}, 64'(err), 64'(0));
    check({phase, "_n_words"}, 64'(n_words), 64'(0));
  endtask

  logic [7:0] prog8 [8];
  logic [7:0] ovf   [17];

  initial begin
    prog8 = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    for (int i = 0; i < 17; i++) ovf[i] = 8'(i + 1);

    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_last  = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // normal load, source always valid (stalls through the WRITE cycles)
    exp_q.push_back({4'd0, 32'h00A00513});
    exp_q.push_back({4'd4, 32'h00100593});
    do_start();
    for (int i = 0; i < 8; i++) send_byte(prog8[i], i == 7, 0);
    tick();
    check("normal_done", 64'(done), 64'(1));
    check("normal_err", 64'(err), 64'(0));
    check("normal_core_rst_n", 64'(core_rst_n), 64'(1));
    check("normal_n_words", 64'(n_words), 64'(2));
    check("normal_waddr", 64'(bus.mem_waddr), 64'(8));
    check("normal_busy", 64'(busy), 64'(0));
    check("normal_q_empty", 64'(exp_q.size()), 64'(0));

    // reload with random gaps between bytes
    exp_q.push_back({4'd0, 32'h00A00513});
    exp_q.push_back({4'd4, 32'h00100593});
    do_start();
    for (int i = 0; i < 8; i++) send_byte(prog8[i], i == 7, 3);
    tick();
    check("gaps_state", 64'(dbg_state), 64'(S_DONE));
    check("gaps_n_words", 64'(n_words), 64'(2));
    check("gaps_q_empty", 64'(exp_q.size()), 64'(0));

    // partial final word: only the first word is written
    exp_q.push_back({4'd0, 32'h00A00513});
    do_start();
    for (int i = 0; i < 6; i++) send_byte(prog8[i], i == 5, 0);
    tick();
    check("partial_err", 64'(err), 64'(1));
    check("partial_done", 64'(done), 64'(0));
    check("partial_core_rst_n", 64'(core_rst_n), 64'(0));
    check("partial_n_words", 64'(n_words), 64'(1));
    tick();
    check("partial_err_holds", 64'(dbg_state), 64'(S_ERR));
    check("partial_q_empty", 64'(exp_q.size()), 64'(0));

    // overflow: 4-word memory, 17 bytes without last
    exp_q.push_back({4'd0,  32'h04030201});
    exp_q.push_back({4'd4,  32'h08070605});
    exp_q.push_back({4'd8,  32'h0C0B0A09});
    exp_q.push_back({4'd12, 32'h100F0E0D});
    do_start();
    for (int i = 0; i < 16; i++) send_byte(ovf[i], 1'b0, 0);
    tick();
    check("ovf_pre_state", 64'(dbg_state), 64'(S_LOAD));
    check("ovf_pre_n_words", 64'(n_words), 64'(4));
    check("ovf_no_wrap_addr", 64'(bus.mem_waddr), 64'(12));
    send_byte(ovf[16], 1'b0, 0);
    tick();
    check("ovf_err", 64'(err), 64'(1));
    check("ovf_done", 64'(done), 64'(0));
    check("ovf_n_words", 64'(n_words), 64'(4));
    check("ovf_waddr", 64'(bus.mem_waddr), 64'(12));
    check("ovf_q_empty", 64'(exp_q.size()), 64'(0));

    // reset mid-load, then a one-word reload
    do_start();
    send_byte(8'hEF, 1'b0, 0);
    send_byte(8'hBE, 1'b0, 0);
    check("midload_busy", 64'(busy), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_state", 64'(dbg_state), 64'(S_IDLE));
    exp_q.push_back({4'd0, 32'h00001137});
    do_start();
    send_byte(8'h37, 1'b0, 0);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b1, 0);
    tick();
    check("reload_done", 64'(done), 64'(1));
    check("reload_core_rst_n", 64'(core_rst_n), 64'(1));
    check("reload_n_words", 64'(n_words), 64'(1));
    check("reload_waddr", 64'(bus.mem_waddr), 64'(4));
    tick();
    check("final_q_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-serial program loader that writes instructions into the instruction memory before execution. It sits between an external byte source (bench driver or UART receiver) and the write port of the instruction memory. It packs incoming bytes into little-endian 32-bit words and writes them at consecutive word-aligned byte addresses starting at 0. While loading, it holds the core's PC and register bank in reset, then releases them once the last word is written.

## Interface
Parameters:
- XLEN, 32, instruction/word width in bits; fixed at 32 (4 bytes per word)
- INSTR_MEM_W, 10, byte-address width of instruction memory (2**INSTR_MEM_W bytes)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- start  in  1  begin a load; sampled in IDLE, DONE, ERR
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  program byte, least significant byte of each word first
- byte_last  in  1  qualifies byte_valid; final byte of program
- byte_ready  out  1  loader accepts a byte this cycle
- mem_wen  out  1  instruction memory write strobe, one-cycle pulse
- mem_waddr  out  INSTR_MEM_W  word-aligned byte address, bits [1:0] always 0
- mem_wdata  out  XLEN  assembled word
- core_rst_n  out  1  active-low reset to PC and register bank; low while loading
- busy  out  1  high in LOAD and WRITE
- done  out  1  load completed successfully
- err  out  1  load aborted: partial final word or memory overflow
- n_words  out  INSTR_MEM_W-1  words written in current/last load

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE: byte_ready=0, core_rst_n=0. On start, go to LOAD. On entry to LOAD, clear the byte index, mem_waddr, and n_words.
- LOAD: byte_ready=1. A byte is accepted when byte_valid && byte_ready at a rising clock edge.
  - Byte index k (0..3) places the byte into word bits [8k+7:8k], then increments k.
  - When the 4th byte is accepted (k=3), go to WRITE.
  - If byte_last is accepted with k≠3, go to ERR. The partial word is not written.
- WRITE: byte_ready=0, mem_wen=1 for exactly one cycle.
  - mem_waddr and mem_wdata are stable during the pulse.
  - Next edge: mem_waddr += 4, n_words += 1, k = 0.
  - Go to DONE if the word contained byte_last; otherwise go to LOAD.
- Overflow: if a byte is accepted in LOAD after n_words == 2**(INSTR_MEM_W-2), go to ERR. mem_waddr never wraps past the top of memory to 0.
- DONE: core_rst_n=1, done=1, byte_ready=0. Holds until start, which goes to LOAD (a reload: core_rst_n drops the same edge).
- ERR: err=1, core_rst_n=0, byte_ready=0. Leave only on start (to LOAD) or rst.
- start in LOAD or WRITE is ignored. Bytes presented in IDLE, DONE, or ERR are not accepted.

## Timing
- Reset values:
  - state=IDLE
  - byte_ready=0, mem_wen=0, mem_waddr=0, mem_wdata=0
  - core_rst_n=0, busy=0, done=0, err=0, n_words=0
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- First byte_ready=1 appears one cycle after start is sampled.
- Write latency: mem_wen is high in the cycle after the 4th byte is accepted. Peak throughput is 4 bytes per 5 cycles.
- core_rst_n rises in the cycle after the final WRITE cycle, i.e. on entry to DONE.
- rst mid-load: immediate return to IDLE. No further mem_wen; core_rst_n=0.

## Structure
- Add loader_state_t (IDLE, LOAD, WRITE, DONE, ERR) to typedefs_pkg.
- Single module; no sub-module. The byte index, address counter, and word shift register are local.
- Instantiated alongside rom_mem. core_rst_n is ANDed with the system rst_n feeding pc and register_bank.

## Test plan
- Normal load:
  - Stimulus: start, then bytes 13,05,A0,00, 93,05,10,00 with last on the 8th byte.
  - Required response: mem_wen pulses twice, writing 0x00A00513@0 and 0x00100593@4. Then done=1, n_words=2, core_rst_n=1.
- Backpressure and gaps:
  - Stimulus: byte_valid toggled randomly over the same 8 bytes.
  - Required response: identical writes. No byte is accepted while byte_ready=0, including during WRITE cycles.
- Partial final word:
  - Stimulus: 6 bytes with last on the 6th.
  - Required response: exactly one write (@0), err=1, done=0, core_rst_n=0.
- Overflow:
  - Stimulus: INSTR_MEM_W=4 (4 words), send 17 bytes with no last.
  - Required response: 4 writes at addresses 0,4,8,12, then err=1 on the 17th byte. No write to address 0 after the first.
- Reset mid-load and reload:
  - Stimulus: assert rst after 2 accepted bytes, then start and a full 4-byte load.
  - Required response: all outputs return to reset values asynchronously. The reload writes its word @0.
